text_console_writer: RTL and testbench
======================================

Name: text_console_writer

Overview:
Upstream feeder for the 80x30 text-mode display stage. It accepts a stream of ASCII bytes over a valid/ready handshake and turns them into write-port transactions on the dual-port tile RAM: address {row[4:0], col[6:0]}, 7-bit character data. It keeps the cursor position, handles control codes, wraps lines and clears rows or the whole screen. It exports the cursor position so the display stage can draw the reverse-video cursor.

Parameters:
MAX_X, 80, columns per row (column index 0..MAX_X-1, 7 bits)
MAX_Y, 30, rows per screen (row index 0..MAX_Y-1, 5 bits)
BLANK_CHAR, 7'h20, character code written by every clear operation
CLEAR_ON_RESET, 1, 1 = run a full-screen clear on reset release; 0 = start in IDLE

Ports:
clk  input  1  system clock (pixel clock domain of the display stage)
reset  input  1  asynchronous, active-low reset
in_data  input  8  ASCII byte
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a byte this cycle (combinational from state)
ram_we  output  1  tile RAM write enable, registered
ram_addr  output  12  tile RAM write address {row, col}, registered
ram_din  output  7  tile RAM write data, registered
cur_x  output  7  cursor column, registered
cur_y  output  5  cursor row, registered
busy  output  1  a clear operation is in progress (equal to ~in_ready)

Behaviour:
- Reset is asynchronous and active-low: one clock named clk, reset port named reset.
- Reset values: ram_we=0, ram_addr=0, ram_din=0, cur_x=0, cur_y=0.
- State after reset: CLR_SCREEN if CLEAR_ON_RESET=1, otherwise IDLE.
- States are IDLE, CLR_LINE and CLR_SCREEN. in_ready=1 only in IDLE.
- A byte transfers on a clock edge when in_valid and in_ready are both high.
- Outputs are registered, so the RAM write appears in the cycle after acceptance (latency 1). ram_we is a single-cycle pulse per write.
- Printable bytes, 0x20..0x7E:
  - Write in_data[6:0] to {cur_y, cur_x}.
  - If cur_x < MAX_X-1: cur_x+1.
  - Otherwise (auto-wrap): cur_x=0, cur_y=next_row, and enter CLR_LINE.
- CR (0x0D): cur_x=0; no write.
- LF (0x0A): cur_x=0, cur_y=next_row, enter CLR_LINE; no character write.
- BS (0x08):
  - If cur_x > 0: cur_x-1 and write BLANK_CHAR at the new position.
  - If cur_x = 0: no-op, no write.
- FF (0x0C): cur_x=0, cur_y=0, enter CLR_SCREEN.
- All other bytes (other control codes, bit7=1) are consumed and ignored: no write, cursor unchanged.
- next_row = 0 when cur_y = MAX_Y-1; otherwise cur_y+1. There is no scrolling; the new row is blanked instead.
- CLR_LINE:
  - Writes BLANK_CHAR to {cur_y, 0..MAX_X-1}, one address per cycle, in ascending column order.
  - Takes MAX_X cycles; the first write is in the cycle after the triggering accept.
  - The edge that issues the column MAX_X-1 write returns the state to IDLE.
- CLR_SCREEN:
  - Writes BLANK_CHAR row-major over rows 0..MAX_Y-1 and columns 0..MAX_X-1: MAX_X*MAX_Y = 2400 writes.
  - Column counter wraps at MAX_X-1 and then increments the row. Addresses with column >= MAX_X are never written.
  - Returns to IDLE on the edge that issues the last write.
- Cursor is held during clears and is never modified by the clear counters.
- While busy, in_valid is ignored and in_data need not be stable. The source must hold the byte until in_ready.
- Reset asserted mid-clear aborts immediately: outputs go to reset values, and a new clear starts on release if CLEAR_ON_RESET=1.
- Width rules: column arithmetic is 7-bit and row arithmetic is 5-bit. Comparisons are against MAX_X-1 and MAX_Y-1; do not rely on natural overflow.

Decomposition:
- Shared package console_pkg holds:
  - MAX_X and MAX_Y defaults and BLANK_CHAR;
  - ASCII constants CR, LF, BS and FF;
  - the state enum {IDLE, CLR_LINE, CLR_SCREEN};
  - the tile-address concatenation helper, also used by the display stage.
- One sub-module, clear_sequencer: a column/row counter with start_line, start_screen, row_in and done outputs. It generates the clear addresses. The FSM, cursor logic and output registers stay in the top level.

Test Plan:
- Reset with CLEAR_ON_RESET=1 -> exactly 2400 ram_we pulses with din=0x20, addresses 0x000..0x04F through 0xE80..0xECF; in_ready rises the cycle after the last write; cursor (0,0).
- Send 'A' (0x41) at (0,0) -> one cycle later ram_we=1, addr=0x000, din=0x41; cur_x=1.
- Send 80 printable bytes from column 0 of row 0 -> last write at addr 0x04F, then cursor (0,1) and 80 blank writes at 0x080..0x0CF; in_ready low for exactly 80 cycles.
- Cursor at (5,29), send LF -> cursor (0,0) and row 0 cleared at 0x000..0x04F; then CR at x=5 -> x=0 with no write.
- Cursor at (3,2), send BS -> write 0x20 to 0x102 and cursor (2,2); BS at x=0 -> no write, no change.
- Send FF with in_valid held high and the next byte 'B' queued -> 2400 clear writes, then 'B' accepted and written to addr 0x000; bytes 0x07 and 0xC1 -> consumed, no write.

Source files
------------

// File: rtl/console_pkg.sv
// Shared definitions for the text console: geometry defaults, ASCII control
// codes, the controller state type and the tile RAM address packing helper.
package console_pkg;

  localparam int unsigned MAX_X_DEF = 80;
  localparam int unsigned MAX_Y_DEF = 30;
  localparam int unsigned COL_W     = 7;
  localparam int unsigned ROW_W     = 5;
  localparam int unsigned ADDR_W    = ROW_W + COL_W;
  localparam int unsigned CHAR_W    = 7;
  localparam int unsigned BYTE_W    = 8;

  localparam logic [CHAR_W-1:0] BLANK_CHAR_DEF = 7'h20;

  localparam logic [BYTE_W-1:0] BS = 8'h08;
  localparam logic [BYTE_W-1:0] LF = 8'h0A;
  localparam logic [BYTE_W-1:0] FF = 8'h0C;
  localparam logic [BYTE_W-1:0] CR = 8'h0D;

  localparam logic [BYTE_W-1:0] PRINT_LO = 8'h20;
  localparam logic [BYTE_W-1:0] PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLR_LINE   = 2'd1,
    CLR_SCREEN = 2'd2
  } console_state_t;

  // Tile RAM address layout shared with the display stage.
  function automatic logic [ADDR_W-1:0] tile_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/clear_sequencer.sv
// Column/row address counter that walks a single row or the whole screen
// for the blanking operations of the console writer.
module clear_sequencer
  import console_pkg::*;
#(
  parameter int unsigned MAX_X = MAX_X_DEF,
  parameter int unsigned MAX_Y = MAX_Y_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_line,
  input  logic             start_screen,
  input  logic [ROW_W-1:0] row_in,
  input  logic             advance,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             done
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(MAX_X - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MAX_Y - 1);

  logic line_mode;

  // Out of reset the counter is parked at the screen origin in screen mode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col       <= '0;
      row       <= '0;
      line_mode <= 1'b0;
    end else if (start_screen) begin
      col       <= '0;
      row       <= '0;
      line_mode <= 1'b0;
    end else if (start_line) begin
      col       <= '0;
      row       <= row_in;
      line_mode <= 1'b1;
    end else if (advance) begin
      if (col == LAST_COL) begin
        col <= '0;
        if (!line_mode) begin
          row <= (row == LAST_ROW) ? '0 : row + ROW_W'(1);
        end
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Current address is the final one of the operation.
  assign done = (col == LAST_COL) && (line_mode || (row == LAST_ROW));

endmodule

// File: rtl/text_console_writer.sv
// Byte-stream to tile RAM writer for the 80x30 text display: cursor tracking,
// control codes, line wrap and row/screen blanking.
module text_console_writer
  import console_pkg::*;
#(
  parameter int unsigned       MAX_X          = MAX_X_DEF,
  parameter int unsigned       MAX_Y          = MAX_Y_DEF,
  parameter logic [CHAR_W-1:0] BLANK_CHAR     = BLANK_CHAR_DEF,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [CHAR_W-1:0] ram_din,
  output logic [COL_W-1:0]  cur_x,
  output logic [ROW_W-1:0]  cur_y,
  output logic              busy
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(MAX_X - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MAX_Y - 1);

  console_state_t   state;
  logic             accept;
  logic             is_print;
  logic             wrap;
  logic [ROW_W-1:0] next_row;
  logic             start_line;
  logic             start_screen;
  logic [COL_W-1:0] seq_col;
  logic [ROW_W-1:0] seq_row;
  logic             seq_done;

  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;
  assign accept   = in_valid && in_ready;

  // Input decode and the row a newline or wrap lands on (no scrolling).
  always_comb begin
    is_print     = (in_data >= PRINT_LO) && (in_data <= PRINT_HI);
    wrap         = is_print && !(cur_x < LAST_COL);
    next_row     = (cur_y == LAST_ROW) ? '0 : cur_y + ROW_W'(1);
    start_line   = accept && (wrap || (in_data == LF));
    start_screen = accept && (in_data == FF);
  end

  clear_sequencer #(
    .MAX_X (MAX_X),
    .MAX_Y (MAX_Y)
  ) u_clear_sequencer (
    .clk          (clk),
    .reset        (reset),
    .start_line   (start_line),
    .start_screen (start_screen),
    .row_in       (next_row),
    .advance      (busy),
    .col          (seq_col),
    .row          (seq_row),
    .done         (seq_done)
  );

  // Controller FSM, cursor and registered RAM write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= CLEAR_ON_RESET ? CLR_SCREEN : IDLE;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      cur_x    <= '0;
      cur_y    <= '0;
    end else begin
      ram_we <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_print) begin
              ram_we   <= 1'b1;
              ram_addr <= tile_addr(cur_y, cur_x);
              ram_din  <= in_data[CHAR_W-1:0];
              if (wrap) begin
                cur_x <= '0;
                cur_y <= next_row;
                state <= CLR_LINE;
              end else begin
                cur_x <= cur_x + COL_W'(1);
              end
            end else begin
              case (in_data)
                CR: cur_x <= '0;
                LF: begin
                  cur_x <= '0;
                  cur_y <= next_row;
                  state <= CLR_LINE;
                end
                BS: begin
                  if (cur_x != '0) begin
                    cur_x    <= cur_x - COL_W'(1);
                    ram_we   <= 1'b1;
                    ram_addr <= tile_addr(cur_y, cur_x - COL_W'(1));
                    ram_din  <= BLANK_CHAR;
                  end
                end
                FF: begin
                  cur_x <= '0;
                  cur_y <= '0;
                  state <= CLR_SCREEN;
                end
                default: ;
              endcase
            end
          end
        end
        CLR_LINE, CLR_SCREEN: begin
          ram_we   <= 1'b1;
          ram_addr <= tile_addr(seq_row, seq_col);
          ram_din  <= BLANK_CHAR;
          if (seq_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: queue-based screen model checked every cycle,
// directed scenarios with literal expectations, then randomized byte traffic.
module tb_text_console_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [6:0]  ram_din;
  logic [6:0]  cur_x;
  logic [4:0]  cur_y;
  logic        busy;

  text_console_writer dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .cur_x    (cur_x),
    .cur_y    (cur_y),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: cursor, pending blank addresses, expected write port.
  int  m_x, m_y;
  int  m_q[$];
  bit  m_we;
  int  m_addr, m_din;
  int  we_cnt;

  function automatic int nrow(input int y);
    return (y == 29) ? 0 : y + 1;
  endfunction

  task automatic push_row(input int y);
    for (int c = 0; c < 80; c++) m_q.push_back(y * 128 + c);
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_we = 0; m_addr = 0; m_din = 0; we_cnt = 0;
    m_q.delete();
    for (int r = 0; r < 30; r++) push_row(r);
  endtask

  task automatic model_write(input int a, input int d);
    m_we = 1; m_addr = a; m_din = d;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d);
    m_we = 0;
    if (m_q.size() > 0) begin
      model_write(m_q.pop_front(), 32'h20);
    end else if (v) begin
      if (d >= 8'h20 && d <= 8'h7E) begin
        model_write(m_y * 128 + m_x, int'(d[6:0]));
        if (m_x == 79) begin
          m_x = 0; m_y = nrow(m_y); push_row(m_y);
        end else m_x++;
      end else if (d == 8'h0D) begin
        m_x = 0;
      end else if (d == 8'h0A) begin
        m_x = 0; m_y = nrow(m_y); push_row(m_y);
      end else if (d == 8'h08) begin
        if (m_x > 0) begin m_x--; model_write(m_y * 128 + m_x, 32'h20); end
      end else if (d == 8'h0C) begin
        m_x = 0; m_y = 0; push_row(0);
        m_q.delete();
        for (int r = 0; r < 30; r++) push_row(r);
      end
    end
  endtask

  logic       s_v, s_r;
  logic [7:0] s_d;

  // Per-cycle compare of every DUT output against the model.
  always @(posedge clk) begin
    s_v = in_valid; s_d = in_data; s_r = reset;
    #1;
    if (!s_r) model_reset();
    else model_step(s_v, s_d);
    if (ram_we) we_cnt++;
    chk("cyc_we", int'(ram_we), int'(m_we));
    chk("cyc_addr", int'(ram_addr), m_addr);
    chk("cyc_din", int'(ram_din), m_din);
    chk("cyc_x", int'(cur_x), m_x);
    chk("cyc_y", int'(cur_y), m_y);
    chk("cyc_ready", int'(in_ready), (s_r && m_q.size() == 0) ? 1 : 0);
    chk("cyc_busy", int'(busy), (s_r && m_q.size() == 0) ? 0 : 1);
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 5000) begin @(negedge clk); n++; end
    chk(name, int'(in_ready), 1);
  endtask

  // Present a byte and hold it until accepted; returns at the negedge after.
  task automatic send(input logic [7:0] b);
    int n = 0;
    in_data = b; in_valid = 1'b1;
    while (!in_ready && n < 5000) begin @(negedge clk); n++; end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  function automatic logic [7:0] rnd_print();
    return 8'($urandom_range(32, 126));
  endfunction

  int t0, cnt, sel;

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_we", int'(ram_we), 0);
    chk("rst_ready", int'(in_ready), 0);
    reset = 1'b1;
    wait_ready("reset_clear_ready");
    chk("reset_clear_writes", we_cnt, 2400);
    chk("reset_last_addr", int'(ram_addr), 12'hECF);

    send(8'h41);
    chk("A_we", int'(ram_we), 1);
    chk("A_addr", int'(ram_addr), 12'h000);
    chk("A_din", int'(ram_din), 7'h41);
    chk("A_x", int'(cur_x), 1);
    send(8'h0D);
    chk("CR_x", int'(cur_x), 0);

    for (int i = 0; i < 80; i++) send(rnd_print());
    chk("wrap_addr", int'(ram_addr), 12'h04F);
    chk("wrap_x", int'(cur_x), 0);
    chk("wrap_y", int'(cur_y), 1);
    cnt = 0;
    while (!in_ready && cnt < 200) begin cnt++; @(negedge clk); end
    chk("wrap_busy_cycles", cnt, 80);

    for (int i = 0; i < 28; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(rnd_print());
    chk("pos_x", int'(cur_x), 5);
    chk("pos_y", int'(cur_y), 29);
    send(8'h0A);
    chk("LF_wrap_x", int'(cur_x), 0);
    chk("LF_wrap_y", int'(cur_y), 0);
    for (int i = 0; i < 5; i++) send(rnd_print());
    send(8'h0D);
    chk("CR_nowrite", int'(ram_we), 0);
    chk("CR_x5", int'(cur_x), 0);

    send(8'h0A); send(8'h0A);
    for (int i = 0; i < 3; i++) send(rnd_print());
    send(8'h08);
    chk("BS_we", int'(ram_we), 1);
    chk("BS_addr", int'(ram_addr), 12'h102);
    chk("BS_din", int'(ram_din), 7'h20);
    chk("BS_x", int'(cur_x), 2);
    send(8'h0D);
    send(8'h08);
    chk("BS0_we", int'(ram_we), 0);
    chk("BS0_x", int'(cur_x), 0);

    t0 = we_cnt;
    send(8'h0C);
    send(8'h42);
    chk("FF_writes", we_cnt - t0, 2401);
    chk("B_addr", int'(ram_addr), 12'h000);
    chk("B_din", int'(ram_din), 7'h42);
    chk("B_x", int'(cur_x), 1);
    send(8'h07);
    chk("BEL_we", int'(ram_we), 0);
    send(8'hC1);
    chk("C1_we", int'(ram_we), 0);
    chk("C1_x", int'(cur_x), 1);

    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      sel = $urandom_range(0, 99);
      if (sel < 70)      send(rnd_print());
      else if (sel < 78) send(8'h0D);
      else if (sel < 86) send(8'h0A);
      else if (sel < 93) send(8'h08);
      else if (sel < 94) send(8'h0C);
      else               send(8'($urandom_range(0, 255)));
    end

    send(8'h0C);
    repeat (37) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_we", int'(ram_we), 0);
    chk("abort_addr", int'(ram_addr), 0);
    chk("abort_x", int'(cur_x), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    wait_ready("abort_ready");
    chk("abort_clear_writes", we_cnt, 2400);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
